// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read port,
// applies branch/jump redirects (deferred while an access is in flight) and produces IF/ID.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_MUX_CONTROL,
    input  logic        REG_FLUSH,
    input  logic [31:0] BRANCH_OR_JUMP_ADDR,
    input  logic        STALL,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_INSTR,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_addr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_target = BRANCH_OR_JUMP_ADDR & ~32'd3;
    assign w_pc_inc = r_pc + 32'd4;

    assign IMEM_ADDR  = r_pc;
    assign IMEM_READ  = ~RESET;
    assign IFID_PC    = r_ifid_pc;
    assign IFID_INSTR = r_ifid_instr;
    assign IFID_VALID = r_ifid_valid;

    // NOTE: all state uses non-blocking assignments so every branch below sees
    // the pre-edge values of r_pc/r_state, regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_VECTOR;
            r_pend_addr  <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (PC_MUX_CONTROL) begin
                        // The word being fetched now is wrong-path: never let it go valid.
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                        if (!IMEM_BUSYWAIT) begin
                            r_pc <= w_target;
                        end else begin
                            r_pend_addr <= w_target;
                            r_state     <= ST_DRAIN;
                        end
                    end else begin
                        if (REG_FLUSH || (!STALL && IMEM_BUSYWAIT)) begin
                            r_ifid_pc    <= r_pc;
                            r_ifid_instr <= NOP_INSTR;
                            r_ifid_valid <= 1'b0;
                        end else if (!STALL) begin
                            r_ifid_pc    <= r_pc;
                            r_ifid_instr <= IMEM_INSTR;
                            r_ifid_valid <= 1'b1;
                        end
                        if (!STALL && !IMEM_BUSYWAIT) begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Memory cannot abort: keep the old address until it completes,
                    // then discard the returned word and jump to the latest target.
                    r_ifid_pc    <= r_pc;
                    r_ifid_instr <= NOP_INSTR;
                    r_ifid_valid <= 1'b0;
                    if (PC_MUX_CONTROL) begin
                        r_pend_addr <= w_target;
                    end
                    if (!IMEM_BUSYWAIT) begin
                        r_pc    <= PC_MUX_CONTROL ? w_target : r_pend_addr;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// stimulus, compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PC_MUX_CONTROL;
    logic        REG_FLUSH;
    logic [31:0] BRANCH_OR_JUMP_ADDR;
    logic        STALL;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_INSTR;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READ;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_INSTR;
    logic        IFID_VALID;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_waiting;
    logic [31:0] m_pend;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    bit          m_ifid_valid;

    always #5 CLK = ~CLK;

    pc_fetch_unit dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .PC_MUX_CONTROL      (PC_MUX_CONTROL),
        .REG_FLUSH           (REG_FLUSH),
        .BRANCH_OR_JUMP_ADDR (BRANCH_OR_JUMP_ADDR),
        .STALL               (STALL),
        .IMEM_BUSYWAIT       (IMEM_BUSYWAIT),
        .IMEM_INSTR          (IMEM_INSTR),
        .IMEM_ADDR           (IMEM_ADDR),
        .IMEM_READ           (IMEM_READ),
        .IFID_PC             (IFID_PC),
        .IFID_INSTR          (IFID_INSTR),
        .IFID_VALID          (IFID_VALID)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"},  IMEM_ADDR,  m_pc);
        check({tag, ".imem_read"},  {31'd0, IMEM_READ}, 32'd1);
        check({tag, ".ifid_pc"},    IFID_PC,    m_ifid_pc);
        check({tag, ".ifid_instr"}, IFID_INSTR, m_ifid_instr);
        check({tag, ".ifid_valid"}, {31'd0, IFID_VALID}, {31'd0, m_ifid_valid});
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_waiting = 0; m_pend = 32'd0;
        m_ifid_pc = 32'd0; m_ifid_instr = NOP; m_ifid_valid = 0;
    endtask

    // One clock of the fetch rules, described in terms of "what does IF/ID see"
    // and "where does the next fetch go".
    task automatic model_edge(input bit pmc, input bit flush, input bit stall,
                              input bit busy, input logic [31:0] tgt, input logic [31:0] word);
        logic [31:0] aligned = {tgt[31:2], 2'b00};
        logic [31:0] cur = m_pc;
        bit          bubble;
        bit          hold;
        if (m_waiting) begin
            bubble = 1; hold = 0;
            if (pmc) m_pend = aligned;
            if (!busy) begin
                m_pc = m_pend;
                m_waiting = 0;
            end
        end else if (pmc) begin
            bubble = 1; hold = 0;
            if (busy) begin
                m_pend = aligned;
                m_waiting = 1;
            end else begin
                m_pc = aligned;
            end
        end else begin
            hold   = stall && !flush;
            bubble = flush || (!stall && busy);
            if (!stall && !busy) m_pc = cur + 32'd4;
        end
        if (bubble) begin
            m_ifid_pc = cur; m_ifid_instr = NOP; m_ifid_valid = 0;
        end else if (!hold) begin
            m_ifid_pc = cur; m_ifid_instr = word; m_ifid_valid = 1;
        end
    endtask

    // Drive one cycle of inputs (away from the edge), clock, update model, compare.
    task automatic step(input string tag, input bit pmc, input bit flush, input bit stall,
                        input bit busy, input logic [31:0] tgt);
        logic [31:0] word = busy ? $urandom : m_pc + 32'h100;
        PC_MUX_CONTROL = pmc; REG_FLUSH = flush; STALL = stall;
        IMEM_BUSYWAIT = busy; BRANCH_OR_JUMP_ADDR = tgt; IMEM_INSTR = word;
        @(posedge CLK);
        model_edge(pmc, flush, stall, busy, tgt, word);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        check("rst.imem_read", {31'd0, IMEM_READ}, 32'd0);
        check("rst.imem_addr", IMEM_ADDR, 32'd0);
        check("rst.ifid_pc", IFID_PC, 32'd0);
        check("rst.ifid_instr", IFID_INSTR, NOP);
        check("rst.ifid_valid", {31'd0, IFID_VALID}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        PC_MUX_CONTROL = 0; REG_FLUSH = 0; STALL = 0; IMEM_BUSYWAIT = 0;
        BRANCH_OR_JUMP_ADDR = 32'd0; IMEM_INSTR = 32'd0;
        #2;
        apply_reset();

        // Free run from reset vector
        for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 0, 0);
        check("run.addr_16", IMEM_ADDR, 32'h10);
        check("run.last_instr", IFID_INSTR, 32'h10C);
        check("run.last_pc", IFID_PC, 32'hC);

        // Redirect + flush with memory idle
        step("redir_idle", 1, 1, 0, 0, 32'h42);
        check("redir_idle.addr", IMEM_ADDR, 32'h40);
        check("redir_idle.valid", {31'd0, IFID_VALID}, 32'd0);
        step("redir_idle.next", 0, 0, 0, 0, 0);
        check("redir_idle.next_pc", IFID_PC, 32'h40);

        // Redirect while memory busy for 3 cycles
        step("to20", 1, 1, 0, 0, 32'h20);
        step("drain1", 1, 1, 0, 1, 32'h80);
        step("drain2", 0, 0, 0, 1, 0);
        step("drain3", 0, 0, 1, 1, 0);
        check("drain.addr_held", IMEM_ADDR, 32'h20);
        step("drain_exit", 0, 0, 0, 0, 0);
        check("drain.addr_target", IMEM_ADDR, 32'h80);
        check("drain.word_never_valid", {31'd0, IFID_VALID}, 32'd0);

        // Latest redirect wins in DRAIN
        step("late1", 1, 1, 0, 1, 32'h80);
        step("late2", 1, 0, 0, 1, 32'hC0);
        step("late_exit", 0, 0, 0, 0, 0);
        check("late.addr", IMEM_ADDR, 32'hC0);

        // Stall with a valid instruction in IF/ID, then flush during stall
        step("to2c", 1, 1, 0, 0, 32'h2C);
        step("fetch2c", 0, 0, 0, 0, 0);
        step("stall1", 0, 0, 1, 0, 0);
        step("stall2", 0, 0, 1, 0, 0);
        check("stall.addr", IMEM_ADDR, 32'h30);
        check("stall.ifid_pc", IFID_PC, 32'h2C);
        check("stall.valid", {31'd0, IFID_VALID}, 32'd1);
        step("stall_flush", 0, 1, 1, 0, 0);
        check("stall_flush.instr", IFID_INSTR, NOP);
        check("stall_flush.valid", {31'd0, IFID_VALID}, 32'd0);
        check("stall_flush.addr", IMEM_ADDR, 32'h30);

        // Wrap at top of address space
        step("to_top", 1, 1, 0, 0, 32'hFFFF_FFFF);
        step("wrap", 0, 0, 0, 0, 0);
        check("wrap.addr", IMEM_ADDR, 32'h0);

        // Reset in the middle of a drain
        step("pre_rst_drain", 1, 1, 0, 1, 32'h100);
        apply_reset();
        step("post_rst", 0, 0, 0, 0, 0);
        check("post_rst.addr", IMEM_ADDR, 32'h4);
        check("post_rst.pc", IFID_PC, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 9) < 3),
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage and the receiving end of the branch/jump redirect interface.
- Owns the program counter and drives the instruction-memory read port.
- Consumes PC_MUX_CONTROL, REG_FLUSH and BRANCH_OR_JUMP_ADDR from the jump controller in EX, and produces the IF/ID pipeline register.
- Handles memory wait states, hazard stalls, and redirects that arrive while an instruction-memory access is still in flight.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (ADDI x0,x0,0) inserted into IF/ID on flush or bubble.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PC_MUX_CONTROL  input  1  redirect request; PC takes BRANCH_OR_JUMP_ADDR.
- REG_FLUSH  input  1  squash IF/ID contents.
- BRANCH_OR_JUMP_ADDR  input  32  redirect target.
- STALL  input  1  hazard stall from decode; hold PC and IF/ID.
- IMEM_BUSYWAIT  input  1  instruction memory has not completed the current access.
- IMEM_INSTR  input  32  instruction word; valid when IMEM_BUSYWAIT=0.
- IMEM_ADDR  output  32  fetch address.
- IMEM_READ  output  1  read request.
- IFID_PC  output  32  PC of the instruction held in IF/ID.
- IFID_INSTR  output  32  instruction held in IF/ID.
- IFID_VALID  output  1  IF/ID holds a real, unsquashed instruction.

Behaviour:
- Reset (async, immediate)
  - PC=RESET_VECTOR, state=RUN, PEND_ADDR=0.
  - IFID_PC=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0.
  - IMEM_READ=0 while RESET=1, and 1 at all other times.
  - Reset asserted mid-DRAIN abandons the drain; no pending target survives.
- Address rules
  - IMEM_ADDR = PC, combinational from the register.
  - Increment is PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Redirect targets load with bits [1:0] forced to 0.
- State RUN, per rising edge, highest priority first:
  1. PC_MUX_CONTROL=1 and IMEM_BUSYWAIT=0: PC<=target; stay RUN.
  2. PC_MUX_CONTROL=1 and IMEM_BUSYWAIT=1: PEND_ADDR<=target; PC unchanged; go DRAIN. IMEM_ADDR must stay stable because the memory cannot abort an access.
  3. STALL=1: PC and IF/ID hold.
  4. IMEM_BUSYWAIT=1: PC holds; IF/ID<=bubble (NOP_INSTR, VALID=0, IFID_PC=PC).
  5. Otherwise: IF/ID<={PC, IMEM_INSTR, VALID=1}; PC<=PC+4.
- IF/ID flush
  - REG_FLUSH=1 forces IF/ID<=bubble on that edge, overriding cases 3–5 and STALL.
  - REG_FLUSH acts independently of PC_MUX_CONTROL.
- State DRAIN
  - IMEM_READ=1 and IMEM_ADDR=old PC are held; IF/ID held as bubble (VALID=0); STALL ignored.
  - IMEM_BUSYWAIT=0: returned IMEM_INSTR is discarded; PC<=PEND_ADDR; go RUN. The first target fetch starts the next cycle.
  - PC_MUX_CONTROL=1 in DRAIN: PEND_ADDR<=new target (latest wins). If IMEM_BUSYWAIT=0 on the same edge, the new target loads into PC directly.
- Latency
  - Redirect with memory idle: target on IMEM_ADDR 1 cycle after the redirect edge.
  - Redirect with memory busy: target appears 1 cycle after IMEM_BUSYWAIT falls.
- Discard rule: a discarded or squashed instruction never reaches IF/ID with VALID=1.

Test Plan:
- Reset then run, IMEM_BUSYWAIT=0, memory returns addr+0x100: IMEM_ADDR 0,4,8,C on successive cycles; IFID_INSTR 0x100,0x104… with VALID=1, IFID_PC lagging by one cycle.
- At PC=0x10, pulse PC_MUX_CONTROL=REG_FLUSH=1 with target 0x42, memory idle: next IMEM_ADDR=0x40; IF/ID=NOP, VALID=0 for one cycle; next valid IFID_PC=0x40.
- Hold IMEM_BUSYWAIT=1 for 3 cycles at PC=0x20 and redirect to 0x80 in the first busy cycle: IMEM_ADDR stays 0x20 until busy drops; word at 0x20 never VALID; IMEM_ADDR=0x80 the cycle after.
- In DRAIN, issue a second redirect to 0xC0 before busy drops: PC loads 0xC0, not 0x80.
- STALL=1 for 2 cycles at PC=0x30 with VALID instruction in IF/ID: PC and IF/ID unchanged. Same with REG_FLUSH=1 on cycle 2: IF/ID becomes NOP, VALID=0.
- PC=0xFFFF_FFFC, free run: next IMEM_ADDR=0. Assert RESET mid-DRAIN: all outputs return to reset values immediately; fetch resumes at RESET_VECTOR.
